phrase_sequencer: RTL
=====================

# phrase_sequencer

Programmable arrangement sequencer for the audio path. Holds a DEPTH-entry phrase-ID table, written through a simple write port, and walks it one entry per phrase-end pulse from the phrase player. It presents the current phrase ID with a valid flag. It supports a run-time song length, a loop point with loop enable, and stop/restart; it replaces the fixed arrangement lookup as the source of phrase IDs for the phrase player.

## Interface
- ID_W, 5, phrase ID width
- ADDR_W, 8, table address width
- DEPTH, 256, table entries; DEPTH ≤ 2^ADDR_W
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  table write strobe
- wr_addr  in  ADDR_W  table write address; writes with wr_addr ≥ DEPTH are dropped
- wr_data  in  ID_W  table write data
- last_addr  in  ADDR_W  index of final song entry; values ≥ DEPTH are treated as DEPTH-1
- loop_addr  in  ADDR_W  restart index when looping; values > effective last_addr are treated as 0
- loop_en  in  1  1: wrap at end; 0: stop at end
- start  in  1  begin playback from address 0
- stop  in  1  abort playback
- next  in  1  phrase-end pulse from phrase player
- phrase_id  out  ID_W  current phrase ID
- phrase_valid  out  1  phrase_id is valid for playback
- pos  out  ADDR_W  table address of the current or pending entry
- looped  out  1  one-cycle pulse on wrap to loop_addr
- done  out  1  one-cycle pulse on end of song when loop_en=0

## Operation
- Table is a synchronous-read RAM: rd_q <= mem[pos] every cycle. No reset of contents; bench must write before use.
- FSM states: IDLE, FETCH, LOAD, PLAY.
  - IDLE: phrase_valid=0. start → pos=0, FETCH.
  - FETCH (1 cycle): rd_q captures mem[pos]. → LOAD.
  - LOAD (1 cycle): phrase_id <= rd_q, phrase_valid <= 1. → PLAY.
  - PLAY: hold phrase_id. On next:
    - pos < last_addr: pos=pos+1, phrase_valid=0, → FETCH.
    - pos == last_addr, loop_en=1: pos=loop_addr (sanitised), looped=1, phrase_valid=0, → FETCH.
    - pos == last_addr, loop_en=0: done=1, phrase_valid=0, → IDLE. pos holds.
- Priority, all states: stop > start > next.
  - stop: → IDLE, phrase_valid=0, no done pulse, pos holds.
  - start in any state: pos=0, → FETCH, phrase_valid=0.
  - next outside PLAY is ignored. It is not queued.
- last_addr, loop_addr and loop_en are sampled only at the end-of-song decision. They may change freely during play.
- Writes are accepted in every state, including during play.
  - A write to the entry being fetched in the same cycle as FETCH returns the old data (read-before-write).
  - A write to an already-loaded entry does not alter phrase_id until that entry is fetched again.
- Address arithmetic is ADDR_W-bit. pos never exceeds effective last_addr, so no wrap occurs.

## Timing
- Reset values: state IDLE, pos=0, phrase_id=0, phrase_valid=0, looped=0, done=0.
- start sampled at edge t → FETCH after t, LOAD after t+1, phrase_valid=1 and phrase_id valid after t+2.
- next sampled at edge t in PLAY → phrase_valid=0 after t, new phrase_id with valid=1 after t+2. Gap is exactly 2 cycles.
- looped and done are registered and asserted for the single cycle following the edge that sampled the terminating next.
- rst mid-playback clears outputs immediately (asynchronously) and leaves table contents untouched.

## Test plan
- Write entries 0..3 = 19,20,19,21; last_addr=3, loop_en=0; start; pulse next four times → phrase_id 19,20,19,21 each valid 2 cycles after start/next; done pulse on 4th next; phrase_valid=0; state IDLE.
- Same table, loop_en=1, loop_addr=1 → sequence 19,20,19,21,20,19,21,20…; looped pulses on each wrap; pos returns to 1.
- loop_addr=9 with last_addr=3 → wrap goes to address 0 (ID 19).
- last_addr=0 with loop_en=1 → ID at entry 0 is reloaded on every next, with a looped pulse each time.
- stop in PLAY at pos=2 → phrase_valid=0 next cycle, no done. next while IDLE → no change. start → ID 19 after 2 cycles.
- Simultaneous next and stop → IDLE. Simultaneous next and start → pos=0. Write entry 2=7 while pos=2 is playing → phrase_id unchanged until the next fetch of entry 2 returns 7. Assert rst mid-FETCH → all outputs 0 immediately.

Source files
------------

// File: rtl/phrase_sequencer.sv
// Arrangement sequencer: walks a programmable phrase-ID table one entry per
// phrase-end pulse, with run-time song length, loop point and stop/restart.
module phrase_sequencer #(
    parameter int unsigned ID_W   = 5,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ID_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [ADDR_W-1:0] loop_addr,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    input  logic              next,
    output logic [ID_W-1:0]   phrase_id,
    output logic              phrase_valid,
    output logic [ADDR_W-1:0] pos,
    output logic              looped,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StFetch, StLoad, StPlay} state_e;

    // One extra bit so DEPTH == 2^ADDR_W is representable in the range checks.
    localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [ID_W-1:0]   phrase_id_q, phrase_id_d;
    logic              valid_q, valid_d;
    logic              looped_q, looped_d;
    logic              done_q, done_d;

    logic [ID_W-1:0]   mem [DEPTH];
    logic [ID_W-1:0]   rd_q;

    logic [ADDR_W-1:0] eff_last;
    logic [ADDR_W-1:0] loop_tgt;
    logic              wr_ok;

    // Sanitise song length, loop point and write address.
    always_comb begin
        eff_last = ({1'b0, last_addr} >= DepthExt) ? LastIdx : last_addr;
        loop_tgt = (loop_addr > eff_last) ? '0 : loop_addr;
        wr_ok    = wr_en && ({1'b0, wr_addr} < DepthExt);
    end

    // Table RAM: synchronous read of the current position; read-before-write.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        rd_q <= mem[pos_q];
    end

    // Next-state logic; stop beats start beats next.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        phrase_id_d = phrase_id_q;
        valid_d     = valid_q;
        looped_d    = 1'b0;
        done_d      = 1'b0;
        if (stop) begin
            state_d = StIdle;
            valid_d = 1'b0;
        end else if (start) begin
            pos_d   = '0;
            state_d = StFetch;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: ;
                StFetch: state_d = StLoad;
                StLoad: begin
                    phrase_id_d = rd_q;
                    valid_d     = 1'b1;
                    state_d     = StPlay;
                end
                StPlay: begin
                    if (next) begin
                        valid_d = 1'b0;
                        state_d = StFetch;
                        // >= also covers last_addr being lowered below pos mid-song.
                        if (pos_q < eff_last) begin
                            pos_d = pos_q + ADDR_W'(1);
                        end else if (loop_en) begin
                            pos_d    = loop_tgt;
                            looped_d = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pos_q       <= '0;
            phrase_id_q <= '0;
            valid_q     <= 1'b0;
            looped_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            phrase_id_q <= phrase_id_d;
            valid_q     <= valid_d;
            looped_q    <= looped_d;
            done_q      <= done_d;
        end
    end

    assign phrase_id    = phrase_id_q;
    assign phrase_valid = valid_q;
    assign pos          = pos_q;
    assign looped       = looped_q;
    assign done         = done_q;

endmodule
